lca_adder_8bit: RTL and testbench
=================================

Name: lca_adder_8bit

Overview:
- 8-bit two-level carry-lookahead adder with registered outputs.
- Computes {cout, sum} = a + b + cin.
- Inputs are sampled on the rising clock edge. The result appears on registered outputs one cycle later.
- Used as a standalone arithmetic datapath block in the basic-circuits library.

Parameters:
- None. Width is fixed at 8 bits and is not parameterised.

Ports:
- clk   input   1  system clock; all state updates on rising edge
- rst   input   1  asynchronous active-high reset
- a     input   8  operand A, unsigned
- b     input   8  operand B, unsigned
- cin   input   1  carry in
- sum   output  8  registered sum bits [7:0]
- cout  output  1  registered carry out, bit 8 of the result

Behaviour:
- Reset:
  - While rst=1, sum=8'h00 and cout=0 immediately, independent of clk.
  - Outputs hold these values until the first rising clk edge after rst deasserts.
  - Asserting rst mid-operation discards any pending result. No partial update follows.
- Datapath, combinational:
  - Per-bit generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i].
  - Split into two 4-bit lookahead groups, bits [3:0] and [7:4].
  - Each group produces internal carries c[i+1] = g[i] | p[i]&c[i], expanded fully in sum-of-products form with no ripple between bits inside a group.
  - Each group also produces group generate GG and group propagate GP.
- Second-level lookahead:
  - c4 = GG0 | GP0&cin
  - cout_next = GG1 | GP1&GG0 | GP1&GP0&cin
  - No ripple path from group 0 into group 1 other than c4.
- Sum bits: s[i] = p[i] ^ c[i], with c0 = cin.
- Register stage:
  - On each rising clk edge with rst=0, sum <= s[7:0] and cout <= cout_next.
  - Latency is exactly 1 cycle from input sampling edge to output.
  - Throughput is one addition per cycle. There is no handshake or valid signal.
  - Inputs change every cycle freely. Each edge captures the values present at that edge.
- Arithmetic:
  - Unsigned, modulo 2^8 on sum. cout carries the overflow.
  - Max case 255+255+1 = 511 -> sum=8'hFF, cout=1.
  - Signed overflow is not flagged.
- Unknown inputs (X) are not sanitised. Outputs may go X until valid inputs are captured.
- All outputs are driven from flops only. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst asynchronously between edges with sum/cout nonzero -> sum=0 and cout=0 at once. Deassert, apply a=2, b=5, cin=0 -> after the next edge sum=7, cout=0.
- Basic adds, applied one per cycle, results one cycle later:
  - a=1, b=1, cin=0 -> sum=2, cout=0
  - a=20, b=20, cin=1 -> sum=41, cout=0
- Group carry crossing: a=75, b=75, cin=1 -> sum=151, cout=0. Exercises c4 through the second-level lookahead.
- Overflow: a=128, b=128, cin=0 -> sum=0, cout=1. Then a=200, b=20, cin=0 -> sum=220, cout=0 on the following cycle, with back-to-back pipelining verified.
- Full propagate chain:
  - a=8'hFF, b=8'h00, cin=1 -> sum=0, cout=1
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1
- Randomised: 1000 random (a, b, cin) vectors, one per cycle. Compare each result against a+b+cin delayed one cycle. Assert rst at random mid-stream and check outputs clear immediately.

Source files
------------

// File: rtl/lca_adder_8bit_if.sv
// Operand/result bundle for the 8-bit lookahead adder.
// The master drives the operands and carry-in. The slave returns the registered sum and carry-out.
interface lca_adder_8bit_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/lca_adder_8bit.sv
// 8-bit two-level carry-lookahead adder with registered outputs.
// Computes {cout, sum} = a + b + cin with one cycle of latency.
// Two 4-bit lookahead groups are joined by a second-level lookahead on the group generate/propagate terms.
module lca_adder_8bit (
    input  logic                 clk,
    input  logic                 rst,
    lca_adder_8bit_if.slave      bus
);

    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic       gg0, gp0, gg1, gp1;
    logic [7:0] s;
    logic       cout_next;

    // Lookahead datapath: every carry inside a group is a flat sum of products.
    always_comb begin
        g = bus.a & bus.b;
        p = bus.a ^ bus.b;

        // group 0, bits [3:0]
        c[0] = bus.cin;
        c[1] = g[0] | (p[0] & bus.cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bus.cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & bus.cin);
        gg0  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        gp0  = &p[3:0];

        // second level: the only link from group 0 into group 1 is c4
        c[4] = gg0 | (gp0 & bus.cin);

        // group 1, bits [7:4]
        c[5] = g[4] | (p[4] & c[4]);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
        c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4])
             | (p[6] & p[5] & p[4] & c[4]);
        gg1  = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5])
             | (p[7] & p[6] & p[5] & g[4]);
        gp1  = &p[7:4];

        cout_next = gg1 | (gp1 & gg0) | (gp1 & gp0 & bus.cin);
        s         = p ^ c;
    end

    // Output register: an asynchronous clear drops any result that has not yet been registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.sum  <= s;
            bus.cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_lca_adder_8bit.sv
// Testbench for lca_adder_8bit.
// The stimulus pushes each expected 9-bit result into a scoreboard queue.
// A monitor pops an entry and compares it one cycle after each capturing edge.
module tb_lca_adder_8bit;

    logic clk;
    logic rst;

    lca_adder_8bit_if bus ();

    lca_adder_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    logic [8:0] expq [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got cout=%b sum=%h, expected cout=%b sum=%h",
                     name, $time, act[8], act[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Apply one operand set at the falling edge; the next rising edge captures it.
    task automatic drive(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
        @(negedge clk);
        bus.a   = xa;
        bus.b   = xb;
        bus.cin = xc;
        expq.push_back({1'b0, xa} + {1'b0, xb} + {8'd0, xc});
    endtask

    // Assert reset between edges, check the clear is immediate, hold across an edge, then release.
    task automatic reset_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_immediate", {bus.cout, bus.sum}, 9'd0);
        expq.delete();
        @(posedge clk);
        #1 check("rst_hold", {bus.cout, bus.sum}, 9'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare the registered result after every rising edge that has a pending expectation.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("add", {bus.cout, bus.sum}, e);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;
        #1 check("reset_state", {bus.cout, bus.sum}, 9'd0);
        @(negedge clk);
        check("reset_state_clk", {bus.cout, bus.sum}, 9'd0);
        rst = 1'b0;

        // Produce a nonzero result so that the reset clear is visible.
        drive(8'd200, 8'd100, 1'b0);
        reset_pulse();
        drive(8'd2, 8'd5, 1'b0);

        drive(8'd1, 8'd1, 1'b0);
        drive(8'd20, 8'd20, 1'b1);
        drive(8'd75, 8'd75, 1'b1);
        drive(8'd128, 8'd128, 1'b0);
        drive(8'd200, 8'd20, 1'b0);
        drive(8'hFF, 8'h00, 1'b1);
        drive(8'hFF, 8'hFF, 1'b1);
        drive(8'h0F, 8'h01, 1'b0);
        drive(8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 49) == 0)
                reset_pulse();
            drive(8'($urandom), 8'($urandom), 1'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results still pending, expected 0", expq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
